// File: rtl/dma_hold_master.sv
// Memory-to-memory word copier that requests the bus via hold/holdACK, then copies LEN words SRC->DST.
// Optional sticky completion interrupt enabled by defining DMA_HOLD_MASTER_IRQ_EN.
module dma_hold_master #(
  parameter int wide     = 32,
  parameter int LEN_BITS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [31:0]     cfg_data,
  output logic            hold,
  input  logic            holdACK,
  output logic [31:0]     dm_a,
  output logic            dm_we,
  output logic [wide-1:0] dm_d,
  input  logic [wide-1:0] dm_q,
  output logic            busy,
  output logic            done,
  output logic            irq
);

  typedef enum logic [2:0] {IDLE, REQ, RD, WR, REL} state_t;

  state_t              state_reg, state_next;
  logic [31:0]         src_reg, dst_reg, sp_reg, dp_reg;
  logic [LEN_BITS-1:0] len_reg, cnt_reg;
  logic [wide-1:0]     buf_reg;
  logic                done_reg;

  logic cfg_idle, start_wr, len_zero, done_set;

  assign cfg_idle = cfg_we && (state_reg == IDLE);
  assign start_wr = cfg_idle && (cfg_addr == 2'd3) && cfg_data[0];
  assign len_zero = (len_reg == '0);
  // A zero-length start completes immediately without touching the bus.
  assign done_set = (state_reg == REL) || (start_wr && len_zero);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    hold       = 1'b0;
    dm_we      = 1'b0;
    dm_a       = '0;
    dm_d       = '0;
    case (state_reg)
      IDLE: begin
        if (start_wr && !len_zero) state_next = REQ;
      end
      REQ: begin
        hold = 1'b1;
        if (holdACK) state_next = RD;
      end
      RD: begin
        hold       = 1'b1;
        dm_a       = sp_reg;
        state_next = holdACK ? WR : REQ;
      end
      WR: begin
        hold  = 1'b1;
        dm_a  = dp_reg;
        dm_d  = buf_reg;
        dm_we = holdACK;
        if (!holdACK)                       state_next = REQ;
        else if (cnt_reg == LEN_BITS'(1))   state_next = REL;
        else                                state_next = RD;
      end
      REL: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_reg  <= '0;
      dst_reg  <= '0;
      len_reg  <= '0;
      sp_reg   <= '0;
      dp_reg   <= '0;
      cnt_reg  <= '0;
      buf_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      if (cfg_idle) begin
        case (cfg_addr)
          2'd0:    src_reg <= {cfg_data[31:2], 2'b00};
          2'd1:    dst_reg <= {cfg_data[31:2], 2'b00};
          2'd2:    len_reg <= cfg_data[LEN_BITS-1:0];
          default: begin
            if (cfg_data[0]) begin
              sp_reg  <= src_reg;
              dp_reg  <= dst_reg;
              cnt_reg <= len_reg;
            end
          end
        endcase
      end
      // Pointers only advance on a granted cycle, so a lost grant replays the same word.
      if (state_reg == RD && holdACK) buf_reg <= dm_q;
      if (state_reg == WR && holdACK) begin
        sp_reg  <= sp_reg + 32'd4;
        dp_reg  <= dp_reg + 32'd4;
        cnt_reg <= cnt_reg - LEN_BITS'(1);
      end
      if (done_set)      done_reg <= 1'b1;
      else if (start_wr) done_reg <= 1'b0;
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;

`ifdef DMA_HOLD_MASTER_IRQ_EN
  logic irq_reg;
  logic irq_clr_wr;

  assign irq_clr_wr = cfg_we && (cfg_addr == 2'd3) && cfg_data[1];

  always_ff @(posedge clk) begin
    if (rst)                          irq_reg <= 1'b0;
    else if (done_set)                irq_reg <= 1'b1;
    else if (start_wr || irq_clr_wr)  irq_reg <= 1'b0;
  end

  assign irq = irq_reg;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = cfg_data[1];
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_dma_hold_master.sv
// Directed bench for dma_hold_master: table of copy jobs plus grant-loss, lockout, reset and irq sequences.
module tb_dma_hold_master;
  localparam int WIDE     = 32;
  localparam int LEN_BITS = 16;
`ifdef DMA_HOLD_MASTER_IRQ_EN
  localparam logic [31:0] IRQ_EN = 32'd1;
`else
  localparam logic [31:0] IRQ_EN = 32'd0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_we = 1'b0;
  logic [1:0]      cfg_addr = '0;
  logic [31:0]     cfg_data = '0;
  logic            hold;
  logic            holdACK = 1'b0;
  logic [31:0]     dm_a;
  logic            dm_we;
  logic [WIDE-1:0] dm_d;
  logic [WIDE-1:0] dm_q;
  logic            busy, done, irq;

  always #5 clk = ~clk;

  dma_hold_master #(.wide(WIDE), .LEN_BITS(LEN_BITS)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .hold(hold), .holdACK(holdACK), .dm_a(dm_a), .dm_we(dm_we), .dm_d(dm_d),
    .dm_q(dm_q), .busy(busy), .done(done), .irq(irq)
  );

  // Source memory content is a fixed function of the address.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction
  assign dm_q = pat(dm_a);

  int passed = 0, total = 0;
  int cyc = 0, start_cyc = 0;
  int ack_k = 0, hold_age = 0;
  bit drop_armed = 0;
  logic [31:0] drop_addr = '0;
  int drop_len = 0, drop_left = 0;
  bit hold_seen = 0;
  int bad_wr = 0;
  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Grant model: holdACK rises ack_k cycles after hold, with an optional forced drop window.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hold) hold_age = hold_age + 1;
      else      hold_age = 0;
      if (drop_armed && hold && dm_a == drop_addr) begin
        drop_left  = drop_len;
        drop_armed = 0;
      end
      if (drop_left > 0) begin
        holdACK   = 1'b0;
        drop_left = drop_left - 1;
      end else begin
        holdACK = hold && (hold_age > ack_k);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (hold) hold_seen = 1;
      if (dm_we) begin
        wr_a.push_back(dm_a);
        wr_d.push_back(dm_d);
        if (!holdACK) bad_wr = bad_wr + 1;
      end
    end
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endfunction

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    int g;
    g = 0;
    while (busy && g < 500) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("busy_timeout", 32'(busy), 32'd0);
    cycles = cyc - start_cyc;
  endtask

  task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] len_data,
                         input int k, input int n_exp, output int cycles);
    ack_k = k;
    wr_a.delete();
    wr_d.delete();
    hold_seen = 0;
    bad_wr    = 0;
    cfg_write(2'd0, s);
    cfg_write(2'd1, d);
    cfg_write(2'd2, len_data);
    cfg_write(2'd3, 32'h1);
    start_cyc = cyc;
    chk("irq_after_start", 32'(irq), (n_exp == 0) ? IRQ_EN : 32'd0);
    wait_idle(cycles);
  endtask

  task automatic check_log(input logic [31:0] s, input logic [31:0] d, input int n);
    chk("wr_count", 32'(wr_a.size()), 32'(n));
    for (int i = 0; i < n && i < wr_a.size(); i++) begin
      chk("wr_addr", wr_a[i], d + 32'(4 * i));
      chk("wr_data", wr_d[i], pat(s + 32'(4 * i)));
    end
  endtask

  typedef struct {
    logic [31:0] src, dst, len_data;
    int          k, n, exp_cyc;
    logic [31:0] exp_src, exp_dst;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc_meas, g;

    vecs[0] = '{32'h0000_0100, 32'h0000_0200, 32'd3,         2, 3, 10, 32'h0000_0100, 32'h0000_0200};
    vecs[1] = '{32'h0000_0400, 32'h0000_0800, 32'd1,         0, 1, 4,  32'h0000_0400, 32'h0000_0800};
    vecs[2] = '{32'h0000_1001, 32'h0000_2003, 32'h0001_0002, 1, 2, 7,  32'h0000_1000, 32'h0000_2000};
    vecs[3] = '{32'h0000_0040, 32'h0000_0080, 32'h0001_0000, 1, 0, 0,  32'h0000_0040, 32'h0000_0080};
    vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0300, 32'd2,         1, 2, 7,  32'hFFFF_FFFC, 32'h0000_0300};

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold",  32'(hold),  32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_irq",   32'(irq),   32'd0);
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    chk("rst_dm_a",  dm_a,       32'd0);
    chk("rst_dm_d",  dm_d,       32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      do_copy(vecs[v].src, vecs[v].dst, vecs[v].len_data, vecs[v].k, vecs[v].n, cyc_meas);
      $display("vec %0d: src=%08h dst=%08h n=%0d cycles=%0d writes=%0d", v, vecs[v].src,
               vecs[v].dst, vecs[v].n, cyc_meas, wr_a.size());
      chk("cycles",    32'(cyc_meas),  32'(vecs[v].exp_cyc));
      chk("done",      32'(done),      32'd1);
      chk("irq",       32'(irq),       IRQ_EN);
      chk("hold_seen", 32'(hold_seen), (vecs[v].n != 0) ? 32'd1 : 32'd0);
      check_log(vecs[v].exp_src, vecs[v].exp_dst, vecs[v].n);
    end

    // Grant loss for 3 cycles during the write of word 2
    drop_addr  = 32'h0000_3004;
    drop_len   = 3;
    drop_armed = 1;
    do_copy(32'h0000_2000, 32'h0000_3000, 32'd4, 1, 4, cyc_meas);
    $display("grant loss: cycles=%0d writes=%0d", cyc_meas, wr_a.size());
    chk("gl_cycles", 32'(cyc_meas), 32'd16);
    chk("gl_bad_wr", 32'(bad_wr),   32'd0);
    chk("gl_armed",  32'(drop_armed), 32'd0);
    check_log(32'h0000_2000, 32'h0000_3000, 4);

    // Busy lockout: SRC and start writes during a transfer are ignored
    ack_k = 1;
    wr_a.delete();
    wr_d.delete();
    cfg_write(2'd0, 32'h0000_0500);
    cfg_write(2'd1, 32'h0000_0600);
    cfg_write(2'd2, 32'd2);
    cfg_write(2'd3, 32'h1);
    start_cyc = cyc;
    cfg_write(2'd0, 32'h0000_FFF0);
    cfg_write(2'd3, 32'h1);
    wait_idle(cyc_meas);
    $display("lockout: cycles=%0d writes=%0d", cyc_meas, wr_a.size());
    chk("lo_cycles", 32'(cyc_meas), 32'd7);
    check_log(32'h0000_0500, 32'h0000_0600, 2);
    repeat (5) @(posedge clk);
    #1;
    chk("lo_no_restart_busy", 32'(busy), 32'd0);
    chk("lo_no_restart_wr",   32'(wr_a.size()), 32'd2);
    wr_a.delete();
    wr_d.delete();
    cfg_write(2'd3, 32'h1);
    start_cyc = cyc;
    wait_idle(cyc_meas);
    $display("lockout rerun: cycles=%0d writes=%0d", cyc_meas, wr_a.size());
    check_log(32'h0000_0500, 32'h0000_0600, 2);

    // irq clear by CTRL bit1
    chk("irq_before_clr", 32'(irq), IRQ_EN);
    cfg_write(2'd3, 32'h2);
    $display("irq clear: irq=%0b done=%0b", irq, done);
    chk("irq_after_clr",  32'(irq),  32'd0);
    chk("done_after_clr", 32'(done), 32'd1);

    // Reset in the write of word 1 of 5
    ack_k = 0;
    cfg_write(2'd0, 32'h0000_0700);
    cfg_write(2'd1, 32'h0000_0800);
    cfg_write(2'd2, 32'd5);
    cfg_write(2'd3, 32'h1);
    g = 0;
    while (!(hold && dm_a == 32'h0000_0800) && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("reach_wr1", 32'(hold && dm_a == 32'h0000_0800), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    $display("reset mid-op: hold=%0b busy=%0b done=%0b dm_we=%0b", hold, busy, done, dm_we);
    chk("mid_rst_hold",  32'(hold),  32'd0);
    chk("mid_rst_busy",  32'(busy),  32'd0);
    chk("mid_rst_done",  32'(done),  32'd0);
    chk("mid_rst_dm_we", 32'(dm_we), 32'd0);
    rst = 1'b0;
    do_copy(32'h0000_0900, 32'h0000_0A00, 32'd2, 1, 2, cyc_meas);
    $display("post-reset copy: cycles=%0d writes=%0d", cyc_meas, wr_a.size());
    chk("pr_cycles", 32'(cyc_meas), 32'd7);
    chk("pr_done",   32'(done),     32'd1);
    check_log(32'h0000_0900, 32'h0000_0A00, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
